// File: rtl/pci_pkg.sv
// Shared definitions for the PCI bus master: state encoding, command codes and limits.
package pci_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAddr,
      StData,
      StAbort
   } pci_state_e;

   localparam logic [3:0]  CMD_READ       = 4'b0010;
   localparam logic [3:0]  CMD_WRITE      = 4'b0011;
   localparam int unsigned DEVSEL_TIMEOUT = 5;
   localparam int unsigned MAX_LEN        = 4;

   localparam logic [3:0]  CBE_IDLE = 4'hF;
   localparam logic [3:0]  CBE_DATA = 4'h0;

   function automatic logic [2:0] clamp_len(input logic [2:0] req_len);
      return (32'(req_len) > MAX_LEN) ? 3'(MAX_LEN) : req_len;
   endfunction

   function automatic logic [31:0] word_sel(input logic [127:0] words, input logic [1:0] idx);
      return words[32*idx +: 32];
   endfunction

endpackage

// File: rtl/pci_master.sv
// PCI initiator: one address phase followed by a burst of up to four 32-bit data phases,
// with a master-abort when no target claims the cycle. Every bus output comes from a flop.
module pci_master
   import pci_pkg::*;
(
   input  logic         CLK,
   input  logic         RST,
   inout  wire  [31:0]  AD,
   output logic [3:0]   CBE,
   output logic         FRAME,
   output logic         IRDY,
   input  logic         TRDY,
   input  logic         DEVSEL,
   input  logic         req,
   input  logic [3:0]   cmd,
   input  logic [31:0]  addr,
   input  logic [2:0]   len,
   input  logic [127:0] wdata,
   output logic [127:0] rdata,
   output logic         busy,
   output logic         done,
   output logic         err
);

   pci_state_e    state_q, state_d;
   logic          write_q, write_d;
   logic [127:0]  wdata_q, wdata_d;
   logic [127:0]  rdata_q, rdata_d;
   logic [1:0]    idx_q, idx_d;
   logic [2:0]    rem_q, rem_d;
   logic [2:0]    tmo_q, tmo_d;
   logic          seen_q, seen_d;
   logic          frame_q, frame_d;
   logic          irdy_q, irdy_d;
   logic [3:0]    cbe_q, cbe_d;
   logic [31:0]   ad_q, ad_d;
   logic          ad_oe_q, ad_oe_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic          xfer;
   logic          timeout;
   logic          to_idle;

   // A data phase completes only when the target has also claimed the cycle.
   assign xfer    = ~TRDY & ~DEVSEL;
   assign timeout = ~seen_q & DEVSEL & (tmo_q == 3'(DEVSEL_TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      write_d = write_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      idx_d   = idx_q;
      rem_d   = rem_q;
      tmo_d   = tmo_q;
      seen_d  = seen_q;
      frame_d = frame_q;
      irdy_d  = irdy_q;
      cbe_d   = cbe_q;
      ad_d    = ad_q;
      ad_oe_d = ad_oe_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      to_idle = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req && (len != 3'd0)) begin
               state_d = StAddr;
               write_d = (cmd[0] == CMD_WRITE[0]);
               wdata_d = wdata;
               rem_d   = clamp_len(len);
               idx_d   = 2'd0;
               tmo_d   = 3'd0;
               seen_d  = 1'b0;
               frame_d = 1'b0;
               irdy_d  = 1'b1;
               cbe_d   = cmd;
               ad_d    = addr;
               ad_oe_d = 1'b1;
               busy_d  = 1'b1;
            end
         end

         StAddr: begin
            state_d = StData;
            irdy_d  = 1'b0;
            cbe_d   = CBE_DATA;
            frame_d = (rem_q == 3'd1);
            // Reads release AD here, giving the turnaround cycle.
            ad_oe_d = write_q;
            ad_d    = word_sel(wdata_q, idx_q);
         end

         StData: begin
            if (!DEVSEL) begin
               seen_d = 1'b1;
            end else if (!seen_q) begin
               tmo_d = tmo_q + 3'd1;
            end

            // A transfer on the last timeout cycle takes priority over the abort.
            if (xfer) begin
               if (!write_q) begin
                  rdata_d[32*idx_q +: 32] = AD;
               end
               if (rem_q == 3'd1) begin
                  to_idle = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  rem_d   = rem_q - 3'd1;
                  frame_d = (rem_q == 3'd2);
                  ad_d    = word_sel(wdata_q, idx_q + 2'd1);
               end
            end else if (timeout) begin
               state_d = StAbort;
               frame_d = 1'b1;
               irdy_d  = 1'b0;
               ad_oe_d = 1'b0;
            end
         end

         StAbort: begin
            to_idle = 1'b1;
            done_d  = 1'b1;
            err_d   = 1'b1;
         end

         default: begin
            to_idle = 1'b1;
         end
      endcase

      if (to_idle) begin
         state_d = StIdle;
         frame_d = 1'b1;
         irdy_d  = 1'b1;
         ad_oe_d = 1'b0;
         cbe_d   = CBE_IDLE;
         busy_d  = 1'b0;
         idx_d   = 2'd0;
         rem_d   = 3'd0;
         tmo_d   = 3'd0;
         seen_d  = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StIdle;
         write_q <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         idx_q   <= 2'd0;
         rem_q   <= 3'd0;
         tmo_q   <= 3'd0;
         seen_q  <= 1'b0;
         frame_q <= 1'b1;
         irdy_q  <= 1'b1;
         cbe_q   <= CBE_IDLE;
         ad_q    <= '0;
         ad_oe_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         idx_q   <= idx_d;
         rem_q   <= rem_d;
         tmo_q   <= tmo_d;
         seen_q  <= seen_d;
         frame_q <= frame_d;
         irdy_q  <= irdy_d;
         cbe_q   <= cbe_d;
         ad_q    <= ad_d;
         ad_oe_q <= ad_oe_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign AD    = ad_oe_q ? ad_q : 'z;
   assign CBE   = cbe_q;
   assign FRAME = frame_q;
   assign IRDY  = irdy_q;
   assign rdata = rdata_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign err   = err_q;

endmodule

// File: tb/tb_pci_master.sv
// Scoreboard bench for pci_master: a behavioural target drives the bus, a monitor checks
// address phases, data phases and completions against expectations queued at issue time.
module tb_pci_master;
   import pci_pkg::*;

   logic         clk;
   logic         rst;
   wire  [31:0]  ad;
   logic [31:0]  ad_drv;
   logic         ad_oe_tb;
   logic [3:0]   cbe;
   logic         frame;
   logic         irdy;
   logic         trdy;
   logic         devsel;
   logic         req;
   logic [3:0]   cmd;
   logic [31:0]  addr;
   logic [2:0]   len;
   logic [127:0] wdata;
   logic [127:0] rdata;
   logic         busy;
   logic         done;
   logic         err;

   assign ad = ad_oe_tb ? ad_drv : 'z;

   pci_master dut (
      .CLK    (clk),
      .RST    (rst),
      .AD     (ad),
      .CBE    (cbe),
      .FRAME  (frame),
      .IRDY   (irdy),
      .TRDY   (trdy),
      .DEVSEL (devsel),
      .req    (req),
      .cmd    (cmd),
      .addr   (addr),
      .len    (len),
      .wdata  (wdata),
      .rdata  (rdata),
      .busy   (busy),
      .done   (done),
      .err    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [3:0] cmd; logic [31:0] addr; } addr_t;
   typedef struct { bit wr; logic [31:0] data; bit frame; } xfer_t;
   typedef struct { bit err; logic [127:0] rdata; int cycles; } exp_t;

   addr_t        addr_q[$];
   xfer_t        xfer_q[$];
   exp_t         exp_q[$];
   logic [127:0] rdata_m;
   int           n_checks = 0;
   int           n_fail   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: samples mid-cycle, when DUT outputs and bench drives are both settled.
   int dcyc = 0;
   bit prev_abort = 1'b0;
   always @(negedge clk) begin
      exp_t  e;
      addr_t ap;
      xfer_t x;
      if (!rst) begin
         if (done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 1'b1, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("done_err", err, e.err);
               check("done_busy", busy, 1'b0);
               check("rdata", rdata, e.rdata);
               check("data_cycles", 128'(dcyc), 128'(e.cycles));
               check("abort_cycle", prev_abort, e.err);
            end
         end
         if (!frame && irdy) begin
            dcyc = 0;
            if (addr_q.size() == 0) begin
               check("unexpected_addr_phase", 1'b1, 1'b0);
            end else begin
               ap = addr_q.pop_front();
               check("addr_phase_ad", ad, ap.addr);
               check("addr_phase_cbe", cbe, ap.cmd);
               check("addr_phase_busy", busy, 1'b1);
            end
         end
         if (!irdy) dcyc++;
         if (!irdy && xfer_q.size() > 0) begin
            x = xfer_q[0];
            check("data_cbe", cbe, 4'h0);
            if (x.wr) check("write_ad", ad, x.data);
            if (!trdy && !devsel) begin
               check("data_frame", frame, x.frame);
               void'(xfer_q.pop_front());
            end
         end else if (!irdy && !trdy && !devsel) begin
            check("unexpected_transfer", 1'b1, 1'b0);
         end
         prev_abort = !irdy && frame && !(!trdy && !devsel);
      end
   end

   // Issues one request and plays the target. dly: DATA cycles before DEVSEL (>=5: never);
   // waits: per-word wait states (4 bits each) once DEVSEL is asserted.
   task automatic do_xact(input logic [3:0] c, input logic [31:0] a, input logic [2:0] l,
                          input logic [127:0] wd, input logic [127:0] rd, input int dly,
                          input logic [15:0] waits, input bit early);
      int    eff, w, wc, k, kmax, t, cyc;
      bit    ab;
      logic  dv, tr;
      xfer_t x;
      addr_t ap;
      exp_t  e;
      eff = (l > 3'd4) ? 4 : int'(l);
      ab  = (dly >= 5);
      if (eff > 0) begin
         ap.cmd  = c;
         ap.addr = a;
         addr_q.push_back(ap);
         cyc = ab ? 6 : dly;
         if (!ab) begin
            for (int i = 0; i < eff; i++) begin
               x.wr    = c[0];
               x.data  = wd[32*i +: 32];
               x.frame = (i == eff - 1);
               xfer_q.push_back(x);
               if (!c[0]) rdata_m[32*i +: 32] = rd[32*i +: 32];
               cyc += 1 + int'(waits[4*i +: 4]);
            end
         end
         e.err    = ab;
         e.rdata  = rdata_m;
         e.cycles = cyc;
         exp_q.push_back(e);
      end

      @(posedge clk); #2;
      req = 1'b1; cmd = c; addr = a; len = l; wdata = wd;
      @(posedge clk); #2;
      req = 1'b0; cmd = 4'($urandom); addr = $urandom; len = 3'($urandom);
      wdata = {$urandom, $urandom, $urandom, $urandom};
      if (eff == 0) begin
         check("len0_busy", busy, 1'b0);
         check("len0_frame", frame, 1'b1);
         @(posedge clk); #2;
         check("len0_still_idle", busy, 1'b0);
         return;
      end

      @(posedge clk); #2;
      w    = 0;
      wc   = int'(waits[3:0]);
      k    = 0;
      kmax = ab ? 6 : 64;
      while (w < eff && k < kmax) begin
         dv = (k >= dly) ? 1'b0 : 1'b1;
         if (!dv) tr = (wc == 0) ? 1'b0 : 1'b1;
         else     tr = early ? 1'($urandom_range(0, 1)) : 1'b1;
         devsel   = dv;
         trdy     = tr;
         ad_drv   = rd[32*w +: 32];
         ad_oe_tb = !c[0] && !dv;
         req      = 1'($urandom_range(0, 1));
         @(posedge clk); #2;
         if (!dv && !tr) begin
            w++;
            if (w < 4) wc = int'(waits[4*w +: 4]);
         end else if (!dv) begin
            wc--;
         end
         k++;
      end
      devsel = 1'b1; trdy = 1'b1; ad_oe_tb = 1'b0; req = 1'b0;

      t = 0;
      while (busy !== 1'b0 && t < 20) begin
         @(posedge clk); #2;
         t++;
      end
      check("busy_release", busy, 1'b0);
      @(posedge clk); #2;
   endtask

   logic [3:0]   c_r;
   logic [31:0]  a_r;
   logic [2:0]   l_r;
   logic [127:0] wd_r, rd_r;
   int           dly_r;
   logic [15:0]  wt_r;
   bit           early_r;
   xfer_t        xm;
   addr_t        am;

   initial begin
      rst = 1'b1; req = 1'b0; cmd = '0; addr = '0; len = '0; wdata = '0;
      trdy = 1'b1; devsel = 1'b1; ad_drv = '0; ad_oe_tb = 1'b0;
      rdata_m = '0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_frame", frame, 1'b1);
      check("rst_irdy", irdy, 1'b1);
      check("rst_cbe", cbe, 4'hF);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_rdata", rdata, 128'h0);
      rst = 1'b0;

      // Single read, target claims in the second DATA cycle.
      do_xact(CMD_READ, 32'h10, 3'd1, '0, 128'd51653, 1, 16'h0, 1'b0);
      check("single_read_word0", rdata[31:0], 32'h0000C9C5);
      // Four-word write, zero wait states.
      do_xact(CMD_WRITE, 32'h100, 3'd4, {32'd4, 32'd3, 32'd2, 32'd1}, '0, 0, 16'h0, 1'b0);
      // Two-word read with three wait states before the second word.
      do_xact(CMD_READ, 32'h200, 3'd2, '0, {64'h0, 32'hBEEF0002, 32'hBEEF0001}, 0, 16'h0030,
              1'b0);
      // Master abort; early TRDY without DEVSEL must not count.
      do_xact(CMD_READ, 32'h300, 3'd3, '0, {4{32'hDEAD0000}}, 99, 16'h0, 1'b1);
      // Claim and transfer on the last timeout cycle.
      do_xact(CMD_WRITE, 32'h400, 3'd2, {32'h0, 32'h0, 32'hCAFE0002, 32'hCAFE0001}, '0, 4,
              16'h0, 1'b1);
      do_xact(CMD_READ, 32'h500, 3'd0, '0, '0, 0, 16'h0, 1'b0);
      do_xact(CMD_READ, 32'h600, 3'd7, '0, {32'hA4, 32'hA3, 32'hA2, 32'hA1}, 2, 16'h0102,
              1'b0);

      // Reset during the DATA phase of a four-word write.
      am.cmd = CMD_WRITE; am.addr = 32'h700;
      addr_q.push_back(am);
      for (int i = 0; i < 4; i++) begin
         xm.wr = 1'b1; xm.data = 32'h7000 + 32'(i); xm.frame = (i == 3);
         xfer_q.push_back(xm);
      end
      @(posedge clk); #2;
      req = 1'b1; cmd = CMD_WRITE; addr = 32'h700; len = 3'd4;
      wdata = {32'h7003, 32'h7002, 32'h7001, 32'h7000};
      @(posedge clk); #2;
      req = 1'b0;
      @(posedge clk); #2;
      devsel = 1'b0; trdy = 1'b0;
      repeat (2) begin
         @(posedge clk); #2;
      end
      trdy = 1'b1; rst = 1'b1;
      @(posedge clk); #2;
      check("midrst_frame", frame, 1'b1);
      check("midrst_irdy", irdy, 1'b1);
      check("midrst_cbe", cbe, 4'hF);
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      rst = 1'b0; devsel = 1'b1;
      xfer_q.delete();
      rdata_m = '0;
      repeat (3) @(posedge clk);
      #2;
      check("midrst_no_done", done, 1'b0);

      for (int n = 0; n < 40; n++) begin
         c_r     = $urandom_range(0, 1) ? CMD_WRITE : CMD_READ;
         a_r     = $urandom;
         l_r     = 3'($urandom);
         wd_r    = {$urandom, $urandom, $urandom, $urandom};
         rd_r    = {$urandom, $urandom, $urandom, $urandom};
         dly_r   = ($urandom_range(0, 9) < 2) ? 99 : int'($urandom_range(0, 4));
         wt_r    = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                    4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
         early_r = 1'($urandom_range(0, 1));
         do_xact(c_r, a_r, l_r, wd_r, rd_r, dly_r, wt_r, early_r);
      end

      repeat (3) @(posedge clk);
      #2;
      check("pending_done", 128'(exp_q.size()), 128'd0);
      check("pending_addr", 128'(addr_q.size()), 128'd0);
      check("pending_xfer", 128'(xfer_q.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pci_master.md
PCI_MASTER -- requirements
Module: pci_master

Interface
REQ-001 SHALL have one clock, CLK; reset is synchronous and active-high, RST.
REQ-002 SHALL provide these ports:
- CLK  input  1  bus clock; all state changes on rising edge.
- RST  input  1  synchronous reset, active-high.
- AD  inout  32  multiplexed address/data bus.
- CBE  output  4  command during the address phase; byte enables during data phases.
- FRAME  output  1  active-low transaction frame.
- IRDY  output  1  active-low initiator ready.
- TRDY  input  1  active-low target ready.
- DEVSEL  input  1  active-low target claim.
- req  input  1  start request; sampled only in IDLE.
- cmd  input  4  PCI command (cmd[0]=0 read, cmd[0]=1 write).
- addr  input  32  start address.
- len  input  3  word count, 1..4.
- wdata  input  128  write words; word i in bits [32i+31:32i].
- rdata  output  128  read words, same packing.
- busy  output  1  transaction in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  master abort; valid with done.

Function
REQ-003 SHALL implement the states IDLE, ADDR, DATA and ABORT.
REQ-004 IDLE: FRAME=1, IRDY=1, AD hi-Z, CBE=4'hF, busy=0.
REQ-005 IDLE, req=1 and 1<=len<=4: latch cmd, addr, len, wdata; go to ADDR.
REQ-006 IDLE, req=1 with len=0: no transaction; len>4 SHALL be clamped to 4.
REQ-007 ADDR lasts exactly one cycle: FRAME=0, IRDY=1, AD=addr, CBE=cmd, busy=1.
REQ-008 DATA: IRDY=0, CBE=4'b0000, busy=1.
REQ-009 DATA, write: AD SHALL be driven with word[idx].
REQ-010 DATA, read: AD SHALL be hi-Z for the whole DATA state, which gives a turnaround on the first data cycle.
REQ-011 A transfer occurs on a rising edge with IRDY=0 and TRDY=0.
REQ-012 On a read transfer, the master SHALL capture AD into rdata word[idx].
REQ-013 On any transfer, idx SHALL increment and the remaining count SHALL decrement.
REQ-014 TRDY=1 in DATA is a wait state: hold AD, CBE and idx; insert no limit on wait states once DEVSEL is seen.
REQ-015 FRAME SHALL be 1 during the final data phase (remaining=1) while IRDY stays 0.
REQ-016 A transfer with remaining=1 SHALL return to IDLE.
REQ-017 On that return, done=1 and err=0 for one cycle, and rdata SHALL be stable until the next ADDR.
REQ-018 devsel_seen SHALL latch on DEVSEL=0 sampled in DATA.
REQ-019 A timeout counter SHALL count DATA cycles with devsel_seen=0.
REQ-020 If DEVSEL is not seen in the first 5 DATA cycles, go to ABORT.
REQ-021 ABORT lasts one cycle with FRAME=1, IRDY=0, AD hi-Z.
REQ-022 After ABORT, go to IDLE with done=1 and err=1, and leave rdata words not transferred unchanged.
REQ-023 TRDY=0 with DEVSEL=1 SHALL NOT count as a transfer.
REQ-024 If DEVSEL=0 and TRDY=0 on the same edge as the 5th timeout cycle, the transfer wins and there is no abort.
REQ-025 req while busy=1 SHALL be ignored.
REQ-026 Outputs SHALL be registered, with no combinational path from TRDY or DEVSEL to any output.

Reset
REQ-027 On RST=1 at a rising edge: state=IDLE, FRAME=1, IRDY=1, AD hi-Z, CBE=4'hF, busy=0, done=0, err=0, rdata=0, counters=0.
REQ-028 RST mid-transaction SHALL abandon the transaction at the next edge with no done pulse.

Structure
REQ-029 A shared package pci_pkg SHALL hold the state encoding, the command codes CMD_READ=4'b0010 and CMD_WRITE=4'b0011, DEVSEL_TIMEOUT=5 and MAX_LEN=4.
REQ-030 The block SHALL be a single module with no sub-module; the AD tri-state SHALL be a continuous assign gated by a registered output enable.

Verification
REQ-031 Single read: cmd=0010, addr=32'h10, len=1; target asserts DEVSEL/TRDY in the 2nd DATA cycle driving 51653 -> rdata[31:0]=32'h0000C9C5, FRAME=1 in DATA, done=1, err=0.
REQ-032 Burst write: cmd=0011, len=4, wdata words 1,2,3,4; TRDY=0 every cycle -> AD shows 1,2,3,4 on consecutive edges, FRAME rises with word 4, done one cycle later.
REQ-033 Wait states: read len=2 with TRDY deasserted for 3 cycles between words -> AD, CBE and idx held; rdata words captured correctly.
REQ-034 Master abort: DEVSEL held 1 -> ABORT after 5 DATA cycles, FRAME=1/IRDY=0 for one cycle, then done=1, err=1.
REQ-035 RST=1 in DATA of a len=4 write -> next cycle FRAME=1, IRDY=1, AD hi-Z, no done.
REQ-036 len=0 request -> state stays IDLE, busy=0; len=7 -> exactly 4 transfers.
